// File: rtl/ysyx_220066_muldiv_ctrl.sv
// ysyx_220066_muldiv_ctrl
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring
// divider working on operand magnitudes, followed by one sign-fixup cycle.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   valid_in / ready_in : request handshake (accept = valid_in & ready_in & !flush)
//   flush               : abort whatever is in flight, return to IDLE
//   ALUctr, is_w        : funct3 operation select, 32-bit W variant
//   src1, src2          : operands (src1 = multiplicand / dividend)
//   busy                : high while iterating or fixing up
//   valid / out_ready   : result handshake, result held until out_ready
//   result, error       : final value, divide-by-zero flag
module ysyx_220066_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic        flush,
    input  logic [2:0]  ALUctr,
    input  logic        is_w,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    output logic        busy,
    output logic        valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        error
);

    function automatic logic [63:0] f_sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] f_ext32(input logic [31:0] v, input logic sgn);
        return {{32{sgn & v[31]}}, v};
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t         r_state, w_next;
    logic [2:0]     r_op;
    logic           r_w;
    logic [63:0]    r_a, r_b;
    logic           r_load;      // first MUL/DIV cycle prepares magnitudes
    logic [5:0]     r_cnt;
    logic [127:0]   r_acc, r_mcand;
    logic [63:0]    r_sh;        // multiplier (MUL) or dividend/quotient shifter (DIV)
    logic [63:0]    r_rem, r_dvsr;
    logic           r_neg_q, r_neg_r;
    logic [63:0]    r_result;
    logic           r_error;

    logic           w_accept, w_wmode, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [63:0]    w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_dividend, w_short_res;
    logic           w_div0, w_ovf, w_last, w_ge;
    logic [64:0]    w_rem_sh;
    logic [63:0]    w_diff, w_q, w_r, w_div_sel, w_div_res, w_mul_res, w_fix_res;
    logic [127:0]   w_prod;

    assign w_accept = valid_in && ready_in && !flush;

    // is_w only shortens mul and the divide family; mulh* always run 64-bit
    assign w_wmode = r_w && ((r_op == 3'b000) || r_op[2]);
    assign w_a_sgn = (r_op == 3'b001) || (r_op == 3'b010) || (r_op == 3'b100) || (r_op == 3'b110);
    assign w_b_sgn = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b110);
    assign w_a_ext = w_wmode ? f_ext32(r_a[31:0], w_a_sgn) : r_a;
    assign w_b_ext = w_wmode ? f_ext32(r_b[31:0], w_b_sgn) : r_b;
    assign w_a_neg = w_a_sgn && w_a_ext[63];
    assign w_b_neg = w_b_sgn && w_b_ext[63];
    assign w_a_mag = w_a_neg ? (64'd0 - w_a_ext) : w_a_ext;
    assign w_b_mag = w_b_neg ? (64'd0 - w_b_ext) : w_b_ext;

    assign w_div0 = r_op[2] && (w_b_ext == 64'd0);
    assign w_ovf  = r_op[2] && !r_op[0] &&
                    (w_wmode ? ((r_a[31:0] == 32'h8000_0000) && (r_b[31:0] == 32'hFFFF_FFFF))
                             : ((r_a == 64'h8000_0000_0000_0000) && (r_b == 64'hFFFF_FFFF_FFFF_FFFF)));
    assign w_dividend  = w_wmode ? f_sext32(r_a[31:0]) : r_a;
    assign w_short_res = w_div0 ? (r_op[1] ? w_dividend : 64'hFFFF_FFFF_FFFF_FFFF)
                                : (r_op[1] ? 64'd0 : w_dividend);

    assign w_last = (r_cnt == (w_wmode ? 6'd31 : 6'd63));

    // Restoring divide step: shift in next dividend bit, subtract if it fits
    assign w_rem_sh = {r_rem, r_sh[63]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_diff   = w_rem_sh[63:0] - r_dvsr;

    // Sign fixup and result selection
    assign w_prod    = r_neg_q ? (128'd0 - r_acc) : r_acc;
    assign w_mul_res = (r_op[1:0] == 2'b00) ? (w_wmode ? f_sext32(w_prod[31:0]) : w_prod[63:0])
                                            : w_prod[127:64];
    assign w_q       = r_neg_q ? (64'd0 - r_sh) : r_sh;
    assign w_r       = r_neg_r ? (64'd0 - r_rem) : r_rem;
    assign w_div_sel = r_op[1] ? w_r : w_q;
    assign w_div_res = w_wmode ? f_sext32(w_div_sel[31:0]) : w_div_sel;
    assign w_fix_res = r_op[2] ? w_div_res : w_mul_res;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = ALUctr[2] ? S_DIV : S_MUL;
            S_MUL:   if (!r_load && w_last) w_next = S_FIX;
            S_DIV: begin
                if (r_load && (w_div0 || w_ovf)) w_next = S_DONE;
                else if (!r_load && w_last)      w_next = S_FIX;
            end
            S_FIX:   w_next = S_DONE;
            S_DONE: begin
                if (w_accept)       w_next = ALUctr[2] ? S_DIV : S_MUL;
                else if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    // Outputs
    always_comb begin
        ready_in = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
        busy     = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
        valid    = (r_state == S_DONE);
        result   = r_result;
        error    = r_error;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load   <= 1'b0;
            r_cnt    <= 6'd0;
            r_result <= 64'd0;
            r_error  <= 1'b0;
        end else if (!flush) begin
            if (w_accept) begin
                r_op   <= ALUctr;
                r_w    <= is_w;
                r_a    <= src1;
                r_b    <= src2;
                r_load <= 1'b1;
                r_cnt  <= 6'd0;
            end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
                if (r_load) begin
                    r_load  <= 1'b0;
                    r_cnt   <= 6'd0;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_acc   <= 128'd0;
                    r_mcand <= {64'd0, w_a_mag};
                    r_rem   <= 64'd0;
                    r_dvsr  <= w_b_mag;
                    // W divides start with the 32-bit dividend at the top of the shifter
                    if (r_state == S_DIV) r_sh <= w_wmode ? {w_a_mag[31:0], 32'd0} : w_a_mag;
                    else                  r_sh <= w_b_mag;
                    if (w_div0 || w_ovf) begin
                        r_result <= w_short_res;
                        r_error  <= w_div0;
                    end
                end else begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_state == S_MUL) begin
                        if (r_sh[0]) r_acc <= r_acc + r_mcand;
                        r_mcand <= {r_mcand[126:0], 1'b0};
                        r_sh    <= {1'b0, r_sh[63:1]};
                    end else begin
                        r_rem <= w_ge ? w_diff : w_rem_sh[63:0];
                        r_sh  <= {r_sh[62:0], w_ge};
                    end
                end
            end else if (r_state == S_FIX) begin
                r_result <= w_fix_res;
                r_error  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_220066_muldiv_ctrl.sv
module tb_ysyx_220066_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst, valid_in, ready_in, flush, is_w, busy, valid, out_ready, error;
    logic [2:0]  ALUctr;
    logic [63:0] src1, src2, result;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    ysyx_220066_muldiv_ctrl dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .flush(flush),
        .ALUctr(ALUctr), .is_w(is_w), .src1(src1), .src2(src2), .busy(busy),
        .valid(valid), .out_ready(out_ready), .result(result), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          lat;
        int          e0;
    } exp_t;

    exp_t sb[$];
    vec_t vt[23];

    function automatic vec_t mk(input logic [2:0] op, input logic w, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] res, input logic err,
                                input int lat);
        vec_t v;
        v.op = op; v.w = w; v.a = a; v.b = b; v.res = res; v.err = err; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: each rising valid retires the oldest outstanding expectation
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1 && !prev_v) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_valid: valid=1 with nothing outstanding, result=%h", result);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("error", {63'd0, error}, {63'd0, e.err});
                chk("latency", 64'(cyc - e.e0), 64'(e.lat));
                chk("busy_in_done", {63'd0, busy}, 64'd0);
            end
        end
        prev_v = (valid === 1'b1);
    end

    // Wait (bounded) for ready_in, present one request, then scramble the inputs
    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] res, input logic err,
                         input int lat, input bit push);
        int   t = 0;
        exp_t e;
        @(negedge clk);
        while (!ready_in && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!ready_in) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: ready_in=%b after %0d cycles, expected 1", ready_in, t);
        end else begin
            ALUctr = op; is_w = w; src1 = a; src2 = b; valid_in = 1'b1;
            @(posedge clk);
            #1;
            if (push) begin
                e.res = res; e.err = err; e.lat = lat; e.e0 = cyc;
                sb.push_back(e);
            end
            valid_in = 1'b0;
            ALUctr = ~op; is_w = ~w; src1 = ~a; src2 = ~b;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL result_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int nv;
        int t;

        vt[0]  = mk(3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 66);
        vt[1]  = mk(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66);
        vt[2]  = mk(3'b011, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66);
        vt[3]  = mk(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 34);
        vt[4]  = mk(3'b101, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);
        vt[5]  = mk(3'b111, 1'b0, 64'd7, 64'd0, 64'd7, 1'b1, 1);
        vt[6]  = mk(3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b0, 1);
        vt[7]  = mk(3'b110, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1'b0, 1);
        vt[8]  = mk(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 66);
        vt[9]  = mk(3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 66);
        vt[10] = mk(3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 66);
        vt[11] = mk(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 66);
        vt[12] = mk(3'b101, 1'b0, 64'd1000, 64'd7, 64'd142, 1'b0, 66);
        vt[13] = mk(3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 34);
        vt[14] = mk(3'b101, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 1'b0, 34);
        vt[15] = mk(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1);
        vt[16] = mk(3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1);
        vt[17] = mk(3'b100, 1'b1, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);
        vt[18] = mk(3'b110, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1'b1, 1);
        vt[19] = mk(3'b000, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, 1'b0, 66);
        vt[20] = mk(3'b001, 1'b0, 64'd2, 64'd3, 64'd0, 1'b0, 66);
        vt[21] = mk(3'b111, 1'b0, 64'd1000, 64'd7, 64'd6, 1'b0, 66);
        vt[22] = mk(3'b010, 1'b0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 66);

        rst = 1'b1; valid_in = 1'b0; flush = 1'b0; out_ready = 1'b1;
        ALUctr = 3'b000; is_w = 1'b0; src1 = 64'd0; src2 = 64'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", {63'd0, valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_error", {63'd0, error}, 64'd0);
        chk("reset_ready_in", {63'd0, ready_in}, 64'd1);

        for (int i = 0; i < 23; i++) begin
            issue(vt[i].op, vt[i].w, vt[i].a, vt[i].b, vt[i].res, vt[i].err, vt[i].lat, 1'b1);
            drain();
        end

        // Result held while the consumer stalls, then back-to-back accept
        out_ready = 1'b0;
        issue(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 66, 1'b1);
        t = 0;
        while (!valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("hold_reached_done", {63'd0, valid}, 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("hold_valid", {63'd0, valid}, 64'd1);
            chk("hold_ready_in", {63'd0, ready_in}, 64'd0);
            chk("hold_busy", {63'd0, busy}, 64'd0);
        end
        out_ready = 1'b1;
        ALUctr = 3'b101; is_w = 1'b0; src1 = 64'd1000; src2 = 64'd7; valid_in = 1'b1;
        #1;
        chk("b2b_ready_in", {63'd0, ready_in}, 64'd1);
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e.res = 64'd142; e.err = 1'b0; e.lat = 66; e.e0 = cyc;
            sb.push_back(e);
        end
        valid_in = 1'b0; src1 = 64'd0; src2 = 64'd0;
        chk("b2b_valid_drop", {63'd0, valid}, 64'd0);
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        drain();

        // Flush sampled at E0+10 abandons a divide
        issue(3'b100, 1'b0, 64'd1000, 64'd7, 64'd0, 1'b0, 0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        chk("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(posedge clk);
        #1;
        chk("flush_busy_after", {63'd0, busy}, 64'd0);
        chk("flush_ready_in", {63'd0, ready_in}, 64'd1);
        nv = 0;
        repeat (80) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk("flush_no_valid", 64'(nv), 64'd0);

        // Leave error=1 held, then reset sampled at E0+5 mid-divide
        issue(3'b111, 1'b0, 64'd7, 64'd0, 64'd7, 1'b1, 1, 1'b1);
        drain();
        issue(3'b100, 1'b0, 64'd1000, 64'd7, 64'd0, 1'b0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_ready_in", {63'd0, ready_in}, 64'd1);
        chk("rst_mid_result", result, 64'd0);
        chk("rst_mid_error", {63'd0, error}, 64'd0);
        nv = 0;
        repeat (80) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk("rst_mid_no_valid", 64'(nv), 64'd0);

        // Flush wins over a simultaneous request
        @(negedge clk);
        ALUctr = 3'b000; is_w = 1'b0; src1 = 64'd3; src2 = 64'd5;
        valid_in = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0; flush = 1'b0;
        chk("flush_vs_accept_busy", {63'd0, busy}, 64'd0);
        chk("flush_vs_accept_ready", {63'd0, ready_in}, 64'd1);
        nv = 0;
        repeat (70) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk("flush_vs_accept_no_valid", 64'(nv), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_220066_muldiv_ctrl.md
YSYX_220066_MULDIV_CTRL -- requirements
Module: ysyx_220066_muldiv_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous reset, active high.
REQ-004 SHALL have port valid_in, input, 1 bit: operation request.
REQ-005 SHALL have port ready_in, output, 1 bit: request can be accepted this cycle.
REQ-006 SHALL have port flush, input, 1 bit: abort the in-flight operation.
REQ-007 SHALL have port ALUctr, input, 3 bits: RISC-V funct3 encoding; 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-008 SHALL have port is_w, input, 1 bit: 32-bit W variant.
REQ-009 SHALL have ports src1 and src2, input, 64 bits each: operands (src1 dividend/multiplicand).
REQ-010 SHALL have port busy, output, 1 bit: iteration or fixup in progress; drives EX-stage block.
REQ-011 SHALL have port valid, output, 1 bit: result available.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-013 SHALL have port result, output, 64 bits: final value.
REQ-014 SHALL have port error, output, 1 bit: divide-by-zero flag for the held result.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV, FIX, DONE; one-hot or binary encoding at implementer's choice.
REQ-016 SHALL set ready_in = (state==IDLE) || (state==DONE && out_ready) and accept when valid_in && ready_in && !flush.
REQ-017 SHALL latch ALUctr, is_w and both operands at acceptance; later input changes do not affect the operation.
REQ-018 SHALL for ALUctr[2]=0 go to MUL; for ALUctr[2]=1 go to DIV, except as given in REQ-022 and REQ-023.
REQ-019 SHALL iterate K cycles in MUL or DIV (K=64; K=32 when is_w for 000, 100-111), one shift-add or restoring-subtract step per cycle on operand magnitudes, with a 6-bit iteration counter.
REQ-020 SHALL spend one cycle in FIX for sign correction and selection (low or high product, quotient or remainder), then enter DONE.
REQ-021 SHALL assert valid in DONE only; valid first high after the rising edge E0+K+2, where E0 is the accept edge.
REQ-022 SHALL treat divide-by-zero (divisor, or its low 32 bits when is_w, equal to 0) as a shortcut to DONE at E0+1: quotient all ones, remainder = dividend, error=1.
REQ-023 SHALL treat signed overflow (most-negative / -1, div or rem) as a shortcut to DONE at E0+1: quotient = dividend, remainder 0, error=0.
REQ-024 SHALL for is_w use src[31:0] (sign- or zero-extended per op), with result = sign-extension of the 32-bit result bit 31.
REQ-025 SHALL ignore is_w for 001-011.
REQ-026 SHALL treat mulhsu as src1 signed and src2 unsigned.
REQ-027 SHALL hold result, error and valid stable in DONE until out_ready; DONE&&out_ready with no new accept returns to IDLE.
REQ-028 SHALL on DONE&&out_ready&&valid_in, accept back-to-back, with valid falling for at least one cycle.
REQ-029 SHALL assert busy in MUL, DIV and FIX, and keep it low in IDLE and DONE.
REQ-030 SHALL on flush in any state go to IDLE at the next edge with valid=0; flush wins over a simultaneous valid_in.

Reset
REQ-031 SHALL on rst go to IDLE with valid=0, busy=0, result=0, error=0, counter=0; ready_in=1 on the cycle after reset deasserts.
REQ-032 SHALL abandon any operation in progress on rst mid-operation, with no valid pulse.

Verification
REQ-033 SHALL verify: mul src1=3, src2=0xFFFF_FFFF_FFFF_FFFB -> result 0xFFFF_FFFF_FFFF_FFF1, error 0, valid after E0+66.
REQ-034 SHALL verify: mulhu both operands 0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE; mulw 0x7FFF_FFFF*2 -> 0xFFFF_FFFF_FFFF_FFFE, valid after E0+34.
REQ-035 SHALL verify: divu 100/0 -> 0xFFFF_FFFF_FFFF_FFFF, error 1, valid after E0+1; remu 7/0 -> 7, error 1.
REQ-036 SHALL verify: divw src1=0x8000_0000, src2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000, error 0, valid after E0+1; remw on the same operands -> 0.
REQ-037 SHALL verify: rem -7 % 2 -> 0xFFFF_FFFF_FFFF_FFFF; out_ready held 0 for 5 cycles -> result stable, valid high; then out_ready=1 with valid_in -> back-to-back accept.
REQ-038 SHALL verify: div started, flush at E0+10 -> busy 0 and ready_in 1 after E0+11, valid never asserted; rst at E0+5 -> same outcome.
